// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// branch_pkg : shared types for the branch resolve path (predictor states,
//              resolve FSM encoding, queued prediction entry).  Rev 1.0
// ============================================================================
package branch_pkg;

  localparam int BR_XLEN    = 32;
  localparam int INSN_BYTES = 4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pred_state_e;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } brs_state_e;

  typedef struct packed {
    logic               taken;
    logic [BR_XLEN-1:0] pc;
    logic [BR_XLEN-1:0] target;
  } q_entry_t;

endpackage
`default_nettype wire

// File: rtl/branch_pred_queue.sv
`default_nettype none
// ============================================================================
// branch_pred_queue : circular FIFO of in-flight predictions with synchronous
//                     clear (clear wins over push/pop).  Rev 1.0
// ============================================================================
module branch_pred_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 65
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);
  localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   c_FULL    = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [AW:0]       r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign full      = (r_count == c_FULL);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rd_data   = r_mem[r_head];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + c_PTR_ONE;
      if (w_do_pop)  r_head <= r_head + c_PTR_ONE;
      if (w_do_push && !w_do_pop)      r_count <= r_count + c_CNT_ONE;
      else if (w_do_pop && !w_do_push) r_count <= r_count - c_CNT_ONE;
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push && !clear) r_mem[r_tail] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// branch_resolve_unit : matches queued IF predictions against EX outcomes,
//                       trains the predictor, flushes on mispredict.  Rev 1.0
// ============================================================================
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  input  logic [XLEN-1:0]          pred_pc,
  input  logic [XLEN-1:0]          pred_target,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [XLEN-1:0]          res_target,
  output logic                     res_ready,
  output logic                     upd_valid,
  output logic                     upd_taken,
  output logic                     flush,
  output logic [XLEN-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [CNT_W-1:0]         branch_cnt,
  output logic [CNT_W-1:0]         mispredict_cnt
);

  localparam int                DATA_W     = $bits(q_entry_t);
  localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]   c_INSN_INC = XLEN'(INSN_BYTES);

  brs_state_e        r_state;
  brs_state_e        w_state_nxt;
  q_entry_t          w_wr_entry;
  q_entry_t          w_head;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_full;
  logic              w_empty;
  logic              w_in_run;
  logic              w_push;
  logic              w_res_fire;
  logic              w_mispredict;
  logic              r_upd_valid;
  logic              r_upd_taken;
  logic              r_flush;
  logic [XLEN-1:0]   r_redirect_pc;
  logic [CNT_W-1:0]  r_branch_cnt;
  logic [CNT_W-1:0]  r_mispredict_cnt;

  assign w_in_run   = (r_state == RUN);
  assign pred_ready = !w_full && w_in_run;
  assign res_ready  = !w_empty && w_in_run;
  assign w_push     = pred_valid && pred_ready;
  assign w_res_fire = res_valid && res_ready;

  assign w_wr_entry.taken  = pred_taken;
  assign w_wr_entry.pc     = pred_pc;
  assign w_wr_entry.target = pred_target;
  assign w_head            = w_rd_data;

  assign w_mispredict = w_res_fire &&
                        ((w_head.taken != res_taken) ||
                         (w_head.taken && res_taken && (w_head.target != res_target)));

  // A mispredict clears the queue, discarding the same-cycle wrong-path push.
  branch_pred_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push),
    .pop     (w_res_fire),
    .clear   (w_mispredict),
    .wr_data (w_wr_entry),
    .rd_data (w_rd_data),
    .count   (q_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_mispredict) w_state_nxt = RECOVER;
      RECOVER: w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= RUN;
      r_upd_valid      <= 1'b0;
      r_upd_taken      <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_pc    <= '0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_upd_valid <= w_res_fire;
      r_upd_taken <= w_res_fire && res_taken;
      r_flush     <= w_mispredict;
      if (w_res_fire && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + c_CNT_ONE;
      if (w_mispredict) begin
        r_redirect_pc <= res_taken ? res_target : (w_head.pc + c_INSN_INC);
        if (r_mispredict_cnt != '1)
          r_mispredict_cnt <= r_mispredict_cnt + c_CNT_ONE;
      end
    end
  end

  assign upd_valid      = r_upd_valid;
  assign upd_taken      = r_upd_taken;
  assign flush          = r_flush;
  assign redirect_pc    = r_redirect_pc;
  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// tb_branch_resolve_unit : directed + random stimulus against a queue-based
//                          reference model; narrow counters expose saturation.
// ============================================================================
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              pred_valid, pred_taken, pred_ready;
  logic [XLEN-1:0]   pred_pc, pred_target;
  logic              res_valid, res_taken, res_ready;
  logic [XLEN-1:0]   res_target;
  logic              upd_valid, upd_taken, flush;
  logic [XLEN-1:0]   redirect_pc;
  logic [$clog2(DEPTH):0] q_count;
  logic [CNT_W-1:0]  branch_cnt, mispredict_cnt;

  branch_resolve_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .res_ready(res_ready), .upd_valid(upd_valid), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc), .q_count(q_count),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          taken;
    logic [31:0] pc;
    logic [31:0] target;
  } ent_t;

  ent_t        mq[$];
  int          checks = 0;
  int          failures = 0;
  bit          m_recover, m_upd_valid, m_upd_taken, m_flush;
  logic [31:0] m_redirect;
  int          m_bcnt, m_mcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_recover = 0; m_upd_valid = 0; m_upd_taken = 0; m_flush = 0;
    m_redirect = 0; m_bcnt = 0; m_mcnt = 0;
  endtask

  // Called just after a rising edge; applies inputs for one cycle and checks.
  task automatic step(input bit pv, input bit pt, input logic [31:0] ppc, input logic [31:0] ptg,
                      input bit rv, input bit rt, input logic [31:0] rtg);
    bit   exp_pr, exp_rr, push, pop, mis;
    ent_t e, n;
    pred_valid = pv; pred_taken = pt; pred_pc = ppc; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
    #1;
    exp_pr = !m_recover && (mq.size() < DEPTH);
    exp_rr = !m_recover && (mq.size() > 0);
    check("pred_ready", pred_ready, exp_pr);
    check("res_ready", res_ready, exp_rr);
    push = pv && exp_pr;
    pop  = rv && exp_rr;
    mis  = 0;
    m_upd_valid = 0;
    m_flush = 0;
    if (pop) begin
      e = mq[0];
      mis = (e.taken != rt) || (e.taken && rt && (e.target != rtg));
      m_upd_valid = 1;
      m_upd_taken = rt;
      if (m_bcnt < SAT) m_bcnt++;
      if (mis) begin
        m_flush = 1;
        m_redirect = rt ? rtg : (e.pc + 32'd4);
        if (m_mcnt < SAT) m_mcnt++;
      end
    end
    if (mis) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        n.taken = pt; n.pc = ppc; n.target = ptg;
        mq.push_back(n);
      end
    end
    m_recover = mis;
    @(posedge clk); #1;
    check("upd_valid", upd_valid, m_upd_valid);
    if (m_upd_valid) check("upd_taken", upd_taken, m_upd_taken);
    check("flush", flush, m_flush);
    check("redirect_pc", redirect_pc, m_redirect);
    check("q_count", q_count, mq.size());
    check("branch_cnt", branch_cnt, m_bcnt);
    check("mispredict_cnt", mispredict_cnt, m_mcnt);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_one(input bit t, input logic [31:0] pc, input logic [31:0] tg);
    step(1, t, pc, tg, 0, 0, 0);
  endtask

  // Resolve the oldest entry with its own predicted outcome (no mispredict).
  task automatic resolve_ok(input bit pv, input logic [31:0] ppc);
    if (mq.size() > 0) step(pv, 1, ppc, ppc + 32'h40, 1, mq[0].taken, mq[0].target);
    else               step(pv, 1, ppc, ppc + 32'h40, 1, 0, 0);
  endtask

  initial begin
    reset = 1;
    pred_valid = 0; pred_taken = 0; pred_pc = 0; pred_target = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_q_count", q_count, 0);
    check("rst_flush", flush, 0);
    check("rst_upd_valid", upd_valid, 0);
    check("rst_branch_cnt", branch_cnt, 0);
    check("rst_redirect", redirect_pc, 0);
    reset = 0;

    // Correct taken prediction
    push_one(1, 32'h100, 32'h200);
    step(0, 0, 0, 0, 1, 1, 32'h200);
    check("dir_ok_upd_taken", upd_taken, 1);
    check("dir_ok_branch_cnt", branch_cnt, 1);

    // Direction mispredict, flush lasts exactly one cycle
    push_one(0, 32'h100, 32'h0);
    step(0, 0, 0, 0, 1, 1, 32'h180);
    check("dir_mis_redirect", redirect_pc, 32'h180);
    check("dir_mis_cnt", mispredict_cnt, 1);
    idle();
    check("dir_mis_flush_drop", flush, 0);

    // Target mispredict and pc+4 wrap
    push_one(1, 32'h100, 32'h200);
    step(0, 0, 0, 0, 1, 1, 32'h240);
    check("tgt_mis_redirect", redirect_pc, 32'h240);
    idle();
    push_one(1, 32'hFFFF_FFFC, 32'h10);
    step(0, 0, 0, 0, 1, 0, 32'h0);
    check("wrap_redirect", redirect_pc, 32'h0);
    idle();

    // Fill the queue, then simultaneous push/pop traffic
    for (int i = 0; i < DEPTH; i++) push_one(i[0], 32'h1000 + 32'(i) * 4, 32'h2000 + 32'(i) * 8);
    check("full_q_count", q_count, DEPTH);
    step(1, 0, 32'h3000, 0, 0, 0, 0);
    resolve_ok(1, 32'h3100);
    resolve_ok(1, 32'h3200);
    resolve_ok(1, 32'h3300);
    while (mq.size() > 0) resolve_ok(0, 0);

    // Oldest of three mispredicts while IF pushes: everything discarded
    for (int i = 0; i < 3; i++) push_one(1, 32'h4000 + 32'(i) * 4, 32'h5000);
    step(1, 1, 32'h4100, 32'h5100, 1, 0, 32'h0);
    check("mis3_q_count", q_count, 0);
    step(1, 1, 32'h4200, 32'h5200, 1, 1, 32'h5200);

    // Resolve on empty is ignored
    step(0, 0, 0, 0, 1, 1, 32'h123);
    check("empty_res_upd", upd_valid, 0);

    // Random traffic; also drives both counters into saturation
    for (int i = 0; i < 600; i++) begin
      bit          pv, rv, rt;
      logic [31:0] rtg;
      pv  = ($urandom_range(0, 99) < 55);
      rv  = ($urandom_range(0, 99) < 60);
      rt  = $urandom_range(0, 1);
      rtg = {$urandom_range(0, 7), 2'b00};
      if (mq.size() > 0 && $urandom_range(0, 99) < 80) begin
        rt = mq[0].taken;
        rtg = mq[0].target;
      end
      step(pv, $urandom_range(0, 1), $urandom, {$urandom_range(0, 7), 2'b00}, rv, rt, rtg);
    end
    check("sat_branch_cnt", branch_cnt, SAT);
    check("sat_mispredict_cnt", mispredict_cnt, SAT);

    // Asynchronous reset with entries queued
    while (m_recover) idle();
    while (mq.size() > 0) resolve_ok(0, 0);
    push_one(1, 32'h600, 32'h700);
    push_one(0, 32'h604, 32'h0);
    #2 reset = 1;
    #1;
    check("async_q_count", q_count, 0);
    check("async_branch_cnt", branch_cnt, 0);
    @(posedge clk); #1;
    reset = 0;
    model_reset();

    // Asynchronous reset while flush is high
    push_one(1, 32'h800, 32'h900);
    step(0, 0, 0, 0, 1, 0, 32'h0);
    #1 reset = 1;
    #1;
    check("async_flush", flush, 0);
    check("async_redirect", redirect_pc, 0);
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
